// File: rtl/load_store_unit_pkg.sv
// Shared load/store funct3 codes, access-check record and funct3 legality helper.
package load_store_unit_pkg;

  localparam logic [2:0] LOAD_LB     = 3'b000;
  localparam logic [2:0] LOAD_LH     = 3'b001;
  localparam logic [2:0] LOAD_LW     = 3'b010;
  localparam logic [2:0] LOAD_LD     = 3'b011;
  localparam logic [2:0] LOAD_LBU    = 3'b100;
  localparam logic [2:0] LOAD_LHU    = 3'b101;
  localparam logic [2:0] LOAD_LWU    = 3'b110;
  localparam logic [2:0] STORE_SB    = 3'b000;
  localparam logic [2:0] STORE_SH    = 3'b001;
  localparam logic [2:0] STORE_SW    = 3'b010;
  localparam logic [2:0] STORE_SD    = 3'b011;
  localparam logic [2:0] FUNCT3_RSVD = 3'b111;

  typedef struct packed {
    logic illegal;
    logic misaligned;
    logic crossing;
  } access_chk_t;

  // Doubleword and LWU only exist on RV64; stores have no unsigned forms.
  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3,
                                          input logic xlen64);
    logic bad;
    bad = (funct3 == FUNCT3_RSVD) || (write && funct3[2]);
    if (!xlen64 && ((funct3 == LOAD_LD) || (funct3 == LOAD_LWU) || (write && funct3 == STORE_SD)))
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and memory-side beat bundle for the load/store unit.
interface load_store_unit_if #(parameter int XLEN = 32) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_address;
  logic [XLEN-1:0] req_store_data;
  logic            resp_valid;
  logic [XLEN-1:0] resp_load_data;
  logic            resp_misaligned;
  logic            resp_illegal;

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_store_data,
    input  req_ready, resp_valid, resp_load_data, resp_misaligned, resp_illegal
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_store_data,
    output req_ready, resp_valid, resp_load_data, resp_misaligned, resp_illegal
  );
endinterface

interface load_store_unit_mem_if #(parameter int XLEN = 32) ();
  localparam int BYTES = XLEN / 8;
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_write;
  logic [XLEN-1:0]  mem_address;
  logic [XLEN-1:0]  mem_write_data;
  logic [BYTES-1:0] mem_write_mask;
  logic [XLEN-1:0]  mem_read_data;

  modport master (
    output mem_valid, mem_write, mem_address, mem_write_data, mem_write_mask,
    input  mem_ready, mem_read_data
  );
  modport slave (
    input  mem_valid, mem_write, mem_address, mem_write_data, mem_write_mask,
    output mem_ready, mem_read_data
  );
endinterface

// File: rtl/load_store_unit_lsu_align.sv
// Combinational lane alignment: store data/mask placement over two words and load
// extraction with sign/zero extension. No state, no handshake.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [1:0]                size_log2,
  input  logic                      unsigned_load,
  input  logic [XLEN-1:0]           store_data,
  input  logic [2*XLEN-1:0]         read_buf,
  output logic [2*XLEN-1:0]         write_vec,
  output logic [2*(XLEN/8)-1:0]     write_mask,
  output logic [XLEN-1:0]           load_result
);
  localparam int BYTES = XLEN / 8;

  logic [7:0]      size_mask;
  logic [XLEN-1:0] shifted;
  logic            sign;
  logic            fill;

  always_comb begin
    size_mask = 8'h00;
    case (size_log2)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    write_vec  = {{XLEN{1'b0}}, store_data} << {offset, 3'b000};
    write_mask = (2*BYTES)'(size_mask) << offset;
  end

  always_comb begin
    shifted = XLEN'(read_buf >> {offset, 3'b000});
    sign    = 1'b0;
    case (size_log2)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    fill        = sign & ~unsigned_load;
    load_result = '0;
    for (int i = 0; i < XLEN; i++)
      load_result[i] = (i < (8 << size_log2)) ? shifted[i] : fill;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, 1-2 bus beats, response 1 cycle after last beat.
// Stalls on mem_ready; faults respond at T+1. Define MISALIGNED_SPLIT_EN to split misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  load_store_unit_if.slave     core,
  load_store_unit_mem_if.master mem
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
`ifdef MISALIGNED_SPLIT_EN
  localparam logic [1:0] S_BEAT1 = 2'd2;
`endif
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_address;
  logic [XLEN-1:0] r_store_data;
  logic            resp_valid_q;
  logic            resp_mis_q;
  logic            resp_ill_q;
  logic [XLEN-1:0] resp_data_q;

  access_chk_t     chk;
  logic [OFFW-1:0] req_offset;
  logic [OFFW-1:0] align_mask;
  logic [OFFW+1:0] cross_sum;
  logic            fault;
  logic            fault_mis;

  logic [2*XLEN-1:0]  read_view;
  logic [2*XLEN-1:0]  write_vec;
  logic [2*BYTES-1:0] write_mask_vec;
  logic [XLEN-1:0]    load_result;
  logic [XLEN-1:0]    beat_base;
  logic               in_beat1;
  logic               mem_valid_int;
  logic               drive_write;

  // Request classification happens on the live request so a fault can skip the bus entirely.
  always_comb begin
    req_offset     = core.req_address[OFFW-1:0];
    align_mask     = OFFW'((32'd1 << core.req_funct3[1:0]) - 32'd1);
    cross_sum      = {2'b00, req_offset} + ((OFFW+2)'(1) << core.req_funct3[1:0]);
    chk.illegal    = funct3_illegal(core.req_write, core.req_funct3, XLEN == 64);
    chk.misaligned = |(req_offset & align_mask);
    chk.crossing   = cross_sum > (OFFW+2)'(BYTES);
`ifdef MISALIGNED_SPLIT_EN
    fault     = chk.illegal;
    fault_mis = 1'b0;
`else
    fault     = chk.illegal | chk.misaligned;
    fault_mis = chk.misaligned & ~chk.illegal;
`endif
  end

`ifdef MISALIGNED_SPLIT_EN
  logic            r_crossing;
  logic [XLEN-1:0] lo_buf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crossing <= 1'b0;
      lo_buf     <= '0;
    end else begin
      if (state == S_IDLE && core.req_valid)
        r_crossing <= chk.crossing;
      if (state == S_BEAT0 && mem.mem_ready)
        lo_buf <= mem.mem_read_data;
    end
  end

  // Second beat data is used live; only the first word needs holding.
  assign in_beat1  = (state == S_BEAT1);
  assign read_view = in_beat1 ? {mem.mem_read_data, lo_buf}
                              : {{XLEN{1'b0}}, mem.mem_read_data};
`else
  logic unused_crossing;
  assign unused_crossing = chk.crossing;
  assign in_beat1        = 1'b0;
  assign read_view       = {{XLEN{1'b0}}, mem.mem_read_data};
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .offset        (r_address[OFFW-1:0]),
    .size_log2     (r_funct3[1:0]),
    .unsigned_load (r_funct3[2]),
    .store_data    (r_store_data),
    .read_buf      (read_view),
    .write_vec     (write_vec),
    .write_mask    (write_mask_vec),
    .load_result   (load_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= '0;
      r_address    <= '0;
      r_store_data <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (core.req_valid) begin
            r_write      <= core.req_write;
            r_funct3     <= core.req_funct3;
            r_address    <= core.req_address;
            r_store_data <= core.req_store_data;
            if (fault) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_ill_q   <= chk.illegal;
              resp_mis_q   <= fault_mis;
            end else begin
              state <= S_BEAT0;
            end
          end
        end
        S_BEAT0: begin
          if (mem.mem_ready) begin
`ifdef MISALIGNED_SPLIT_EN
            if (r_crossing) state <= S_BEAT1;
            else
`endif
            begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= r_write ? '0 : load_result;
            end
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        S_BEAT1: begin
          if (mem.mem_ready) begin
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= r_write ? '0 : load_result;
          end
        end
`endif
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat outputs derive only from registered request state, so they hold through stalls.
  assign mem_valid_int = (state == S_BEAT0) || in_beat1;
  assign drive_write   = mem_valid_int && r_write;
  assign beat_base     = {r_address[XLEN-1:OFFW], {OFFW{1'b0}}};

  assign mem.mem_valid      = mem_valid_int;
  assign mem.mem_write      = drive_write;
  assign mem.mem_address    = !mem_valid_int ? '0 :
                              in_beat1 ? beat_base + XLEN'(BYTES) : beat_base;
  assign mem.mem_write_data = !drive_write ? '0 :
                              in_beat1 ? write_vec[2*XLEN-1:XLEN] : write_vec[XLEN-1:0];
  assign mem.mem_write_mask = !drive_write ? '0 :
                              in_beat1 ? write_mask_vec[2*BYTES-1:BYTES]
                                       : write_mask_vec[BYTES-1:0];

  assign core.req_ready       = (state == S_IDLE);
  assign core.resp_valid      = resp_valid_q;
  assign core.resp_load_data  = resp_data_q;
  assign core.resp_misaligned = resp_mis_q;
  assign core.resp_illegal    = resp_ill_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (XLEN=32): vector table driven through a beat/response scoreboard.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    int          nb;
    logic [3:0]  m0;
    logic [31:0] d0;
    logic [3:0]  m1;
    logic [31:0] d1;
    logic [31:0] rd;
    logic        mis;
    logic        ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        wr;
    int          due;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        mis;
    logic        ill;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if     #(.XLEN(32)) core_if ();
  load_store_unit_mem_if #(.XLEN(32)) mem_if ();

  load_store_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .core    (core_if),
    .mem     (mem_if)
  );

  logic [31:0] mem_arr [0:1023];
  assign mem_if.mem_read_data = mem_arr[mem_if.mem_address[11:2]];

  int    n_cmp = 0;
  int    n_err = 0;
  int    ncyc  = 0;
  beat_t beat_q[$];
  resp_t resp_q[$];
  vec_t  vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] sdata, logic [31:0] w0, logic [31:0] w1, int stall,
                              int nb, logic [3:0] m0, logic [31:0] d0, logic [3:0] m1,
                              logic [31:0] d1, logic [31:0] rd, logic mis, logic ill);
    vec_t v;
    v.name = nm; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.w0 = w0; v.w1 = w1;
    v.stall = stall; v.nb = nb; v.m0 = m0; v.d0 = d0; v.m1 = m1; v.d1 = d1;
    v.rd = rd; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  // Scoreboard side: compare every completed beat and every response against the queues.
  always @(negedge clk) begin
    ncyc++;
    if (reset_n && mem_if.mem_valid && mem_if.mem_ready) begin
      check("beat_expected", beat_q.size() != 0, 1);
      if (beat_q.size() != 0) begin
        beat_t b;
        b = beat_q.pop_front();
        check({b.name, "/beat_addr"}, mem_if.mem_address, b.addr);
        check({b.name, "/beat_mask"}, mem_if.mem_write_mask, b.mask);
        check({b.name, "/beat_write"}, mem_if.mem_write, b.wr);
        if (b.wr) check({b.name, "/beat_data"}, mem_if.mem_write_data, b.data);
        check({b.name, "/beat_cycle"}, ncyc, b.due);
      end
    end
    if (reset_n && core_if.resp_valid) begin
      check("resp_expected", resp_q.size() != 0, 1);
      if (resp_q.size() != 0) begin
        resp_t r;
        r = resp_q.pop_front();
        check({r.name, "/resp_data"}, core_if.resp_load_data, r.data);
        check({r.name, "/resp_misaligned"}, core_if.resp_misaligned, r.mis);
        check({r.name, "/resp_illegal"}, core_if.resp_illegal, r.ill);
        check({r.name, "/resp_cycle"}, ncyc, r.due);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int acc;
    int g;
    mem_arr[v.addr[11:2]]         = v.w0;
    mem_arr[v.addr[11:2] + 10'd1] = v.w1;
    @(negedge clk); #1;
    g = 0;
    while (!core_if.req_ready && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    check({v.name, "/req_ready_idle"}, core_if.req_ready, 1);
    acc = ncyc;
    core_if.req_valid      = 1'b1;
    core_if.req_write      = v.wr;
    core_if.req_funct3     = v.f3;
    core_if.req_address    = v.addr;
    core_if.req_store_data = v.sdata;
    mem_if.mem_ready       = (v.stall == 0);
    for (int k = 0; k < v.nb; k++)
      beat_q.push_back('{name: v.name, addr: (v.addr & ~32'h3) + 32'(4 * k),
                         mask: (k == 0) ? v.m0 : v.m1, data: (k == 0) ? v.d0 : v.d1,
                         wr: v.wr, due: acc + 1 + k + v.stall});
    resp_q.push_back('{name: v.name, data: v.rd, mis: v.mis, ill: v.ill,
                       due: acc + 1 + v.nb + v.stall});
    @(posedge clk); #1;
    core_if.req_valid      = 1'b0;
    core_if.req_write      = ~v.wr;
    core_if.req_funct3     = 3'b111;
    core_if.req_address    = 32'hFFFF_FFFF;
    core_if.req_store_data = 32'h0;
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      #1 mem_if.mem_ready = 1'b1;
    end
    g = 0;
    while (resp_q.size() != 0 && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    check({v.name, "/resp_pending"}, resp_q.size(), 0);
    check({v.name, "/beats_pending"}, beat_q.size(), 0);
    resp_q.delete();
    beat_q.delete();
    @(negedge clk); #1;
    check({v.name, "/idle_resp_valid"}, core_if.resp_valid, 0);
    check({v.name, "/idle_resp_data"}, core_if.resp_load_data, 0);
    check({v.name, "/idle_mem_valid"}, mem_if.mem_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
    core_if.req_valid      = 1'b0;
    core_if.req_write      = 1'b0;
    core_if.req_funct3     = 3'b000;
    core_if.req_address    = 32'h0;
    core_if.req_store_data = 32'h0;
    mem_if.mem_ready       = 1'b1;

    vecs.push_back(mk("sw_aligned", 1, STORE_SW, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lb_sign", 0, LOAD_LB, 32'h203, 0, 32'h80112233, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk("lbu_zero", 0, LOAD_LBU, 32'h203, 0, 32'h80112233, 0, 0, 1, 0, 0, 0, 0, 32'h00000080, 0, 0));
    vecs.push_back(mk("sh_upper", 1, STORE_SH, 32'h10A, 32'h1234ABCD, 0, 0, 0, 1, 4'b1100, 32'hABCD0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sb_lane1", 1, STORE_SB, 32'h105, 32'hFFFFFFA5, 0, 0, 0, 1, 4'b0010, 32'hFFFFA500, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lh_sign", 0, LOAD_LH, 32'h106, 0, 32'h80017FFF, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF8001, 0, 0));
    vecs.push_back(mk("lhu_zero", 0, LOAD_LHU, 32'h106, 0, 32'h80017FFF, 0, 0, 1, 0, 0, 0, 0, 32'h00008001, 0, 0));
    vecs.push_back(mk("lw_plain", 0, LOAD_LW, 32'h300, 0, 32'hCAFEF00D, 0, 0, 1, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk("lw_stall2", 0, LOAD_LW, 32'h304, 0, 32'h12345678, 0, 2, 1, 0, 0, 0, 0, 32'h12345678, 0, 0));
    vecs.push_back(mk("ill_111", 0, FUNCT3_RSVD, 32'h100, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("ill_ld32", 0, LOAD_LD, 32'h100, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("ill_lwu32", 0, LOAD_LWU, 32'h100, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("ill_st_uns", 1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef MISALIGNED_SPLIT_EN
    vecs.push_back(mk("sw_cross", 1, STORE_SW, 32'h102, 32'hAABBCCDD, 0, 0, 0, 2, 4'b1100, 32'hCCDD0000, 4'b0011, 32'h0000AABB, 0, 0, 0));
    vecs.push_back(mk("lh_cross", 0, LOAD_LH, 32'h1FF, 0, 32'h11223344, 32'h55667788, 0, 2, 0, 0, 0, 0, 32'hFFFF8811, 0, 0));
    vecs.push_back(mk("lh_in_word", 0, LOAD_LH, 32'h101, 0, 32'h00ABCD00, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFABCD, 0, 0));
    vecs.push_back(mk("sh_cross", 1, STORE_SH, 32'h103, 32'h00005566, 0, 0, 0, 2, 4'b1000, 32'h66000000, 4'b0001, 32'h00000055, 0, 0, 0));
`else
    vecs.push_back(mk("sw_cross", 1, STORE_SW, 32'h102, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("lh_cross", 0, LOAD_LH, 32'h1FF, 0, 32'h11223344, 32'h55667788, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("lh_in_word", 0, LOAD_LH, 32'h101, 0, 32'h00ABCD00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("sh_cross", 1, STORE_SH, 32'h103, 32'h00005566, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`endif

    // Reset values while reset_n is held low.
    #12;
    check("rst_req_ready", core_if.req_ready, 1);
    check("rst_mem_valid", mem_if.mem_valid, 0);
    check("rst_mem_write", mem_if.mem_write, 0);
    check("rst_mem_mask", mem_if.mem_write_mask, 0);
    check("rst_mem_data", mem_if.mem_write_data, 0);
    check("rst_resp_valid", core_if.resp_valid, 0);
    check("rst_resp_data", core_if.resp_load_data, 0);
    check("rst_resp_flags", {core_if.resp_misaligned, core_if.resp_illegal}, 0);
    @(negedge clk); #1 reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // LW stalled by mem_ready=0, then abandoned by a mid-beat reset.
    mem_arr[32'h100 >> 2] = 32'h0BADF00D;
    @(negedge clk); #1;
    mem_if.mem_ready       = 1'b0;
    core_if.req_valid      = 1'b1;
    core_if.req_write      = 1'b0;
    core_if.req_funct3     = LOAD_LW;
    core_if.req_address    = 32'h100;
    @(posedge clk); #1;
    core_if.req_valid      = 1'b0;
    core_if.req_address    = 32'h3F0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("stall_mem_valid", mem_if.mem_valid, 1);
      check("stall_mem_addr", mem_if.mem_address, 32'h100);
      check("stall_mem_mask", mem_if.mem_write_mask, 0);
      check("stall_req_ready", core_if.req_ready, 0);
    end
    reset_n = 1'b0;
    #1;
    check("midrst_mem_valid", mem_if.mem_valid, 0);
    check("midrst_resp_valid", core_if.resp_valid, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    mem_if.mem_ready = 1'b1;
    @(negedge clk); #1;
    check("postrst_req_ready", core_if.req_ready, 1);
    check("postrst_mem_valid", mem_if.mem_valid, 0);
    check("postrst_resp_valid", core_if.resp_valid, 0);

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
